// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer line fetcher.
// Latency: n/a (package). Backpressure: n/a (package).
// Holds the fetch FSM state enum, LCD geometry and line-buffer address width.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } fetch_state_t;

  localparam int LCD_H_PIX     = 480;
  localparam int LCD_V_LINES   = 272;
  localparam int FB_LINE_WORDS = 240;  // two RGB565 pixels per 32-bit word
  localparam int BUF_AW        = 9;    // bit 8 is the bank select

endpackage

// File: rtl/fb_line_fetch.sv
// Wishbone read initiator: streams one scan line of RGB565 words from SDRAM into the line buffer.
// Latency: cyc/stb one cycle after line_req; buf_we one cycle after each ack; >= 2 cycles per word.
// Backpressure: REQ holds stb and address until wb_ack_i; line_req while busy is dropped and flags overrun.
//
// Ports:
//   clk, resetn            - clock, synchronous active-low reset
//   frame_start, line_req  - single-cycle pulses (already synchronised into clk)
//   wb_cyc_o/stb_o/we_o/adr_o, wb_dat_i, wb_ack_i - Wishbone read initiator
//   buf_we, buf_waddr, buf_wdata - line-buffer write port (buf_waddr[8] = bank)
//   busy, done, overrun, line_cnt - status
//
// Optional feature: define FB_LINE_FETCH_DOUBLE_BUF_EN to toggle the line-buffer
// bank at each completed line (bank cleared at frame start). Without it the bank
// bit is constant 0.
module fb_line_fetch
  import fb_pkg::*;
#(
  parameter int              LINE_WORDS = FB_LINE_WORDS,
  parameter int              LINES      = LCD_V_LINES,
  parameter int              ADDR_W     = 21,
  parameter logic [ADDR_W-1:0] FB_BASE  = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_start,
  input  logic              line_req,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  input  logic [31:0]       wb_dat_i,
  input  logic              wb_ack_i,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_waddr,
  output logic [31:0]       buf_wdata,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [8:0]        line_cnt
);

  localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_WORDS);
  localparam logic [7:0]        LAST_IDX = 8'(LINE_WORDS - 1);
  localparam logic [8:0]        LINES_9  = 9'(LINES);

  fetch_state_t      r_state;
  logic              r_cyc;
  logic              r_stb;
  logic [ADDR_W-1:0] r_adr;
  logic              r_buf_we;
  logic [BUF_AW-1:0] r_buf_waddr;
  logic [31:0]       r_buf_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_overrun;
  logic [8:0]        r_line_cnt;
  logic [ADDR_W-1:0] r_line_base;
  logic [7:0]        r_idx;
  logic              r_pend;       // frame_start seen while busy, applied at line end

  logic              w_last;
  logic              w_reload;
  logic [8:0]        w_cnt_next;
  logic              w_bank_bit;

`ifdef FB_LINE_FETCH_DOUBLE_BUF_EN
  logic              r_bank;
  assign w_bank_bit = r_bank;
`else
  assign w_bank_bit = 1'b0;
`endif

  assign w_last     = (r_idx == LAST_IDX);
  assign w_reload   = r_pend | frame_start;
  assign w_cnt_next = r_line_cnt + 9'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_adr       <= FB_BASE;
      r_buf_we    <= 1'b0;
      r_buf_waddr <= '0;
      r_buf_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_line_cnt  <= '0;
      r_line_base <= FB_BASE;
      r_idx       <= '0;
      r_pend      <= 1'b0;
`ifdef FB_LINE_FETCH_DOUBLE_BUF_EN
      r_bank      <= 1'b0;
`endif
    end else begin
      r_buf_we <= 1'b0;
      r_done   <= 1'b0;

      if (line_req && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      if (frame_start && (r_state != ST_IDLE)) r_pend <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_line_cnt  <= '0;
            r_line_base <= FB_BASE;
`ifdef FB_LINE_FETCH_DOUBLE_BUF_EN
            r_bank      <= 1'b0;
`endif
          end
          if (line_req) begin
            r_state <= ST_REQ;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_busy  <= 1'b1;
            r_idx   <= '0;
            // A coincident frame_start means this fetch is line 0.
            r_adr   <= frame_start ? FB_BASE : r_line_base;
          end
        end

        ST_REQ: begin
          if (wb_ack_i) begin
            r_state     <= ST_GAP;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_buf_we    <= 1'b1;
            r_buf_wdata <= wb_dat_i;
            r_buf_waddr <= {w_bank_bit, r_idx};
            // done lines up with the final buffer write
            r_done      <= w_last;
          end
        end

        ST_GAP: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
            // Normal advance first; a pending reload then overrides it.
            if (w_reload || (w_cnt_next == LINES_9)) begin
              r_line_cnt  <= '0;
              r_line_base <= FB_BASE;
            end else begin
              r_line_cnt  <= w_cnt_next;
              r_line_base <= r_line_base + LINE_STEP;
            end
`ifdef FB_LINE_FETCH_DOUBLE_BUF_EN
            r_bank <= w_reload ? 1'b0 : ~r_bank;
`endif
          end else begin
            r_state <= ST_REQ;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_idx   <= r_idx + 8'd1;
            r_adr   <= r_adr + ADR_ONE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = 1'b0;
  assign wb_adr_o  = r_adr;
  assign buf_we    = r_buf_we;
  assign buf_waddr = r_buf_waddr;
  assign buf_wdata = r_buf_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_overrun;
  assign line_cnt  = r_line_cnt;

endmodule

// File: tb/tb_fb_line_fetch.sv
// Directed bench for fb_line_fetch with a small Wishbone responder (data = address).
// Latency: n/a. Backpressure: responder inserts a programmable number of wait cycles per strobe.
module tb_fb_line_fetch;

  localparam int          LW   = 4;
  localparam int          NL   = 3;
  localparam logic [20:0] BASE = 21'h100;
`ifdef FB_LINE_FETCH_DOUBLE_BUF_EN
  localparam logic DBUF = 1'b1;
`else
  localparam logic DBUF = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        frame_start;
  logic        line_req;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [20:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        buf_we;
  logic [8:0]  buf_waddr;
  logic [31:0] buf_wdata;
  logic        busy, done, overrun;
  logic [8:0]  line_cnt;

  int total = 0;
  int bad   = 0;

  // responder / monitor state
  int          wait_n = 0;
  int          wcnt = 0;
  int          ack_cnt = 0;
  int          done_cnt = 0;
  int          adr_changes = 0;
  logic [20:0] held_adr = '0;
  logic [20:0] rd_adr[$];
  logic [8:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  fb_line_fetch #(
    .LINE_WORDS(LW),
    .LINES     (NL),
    .ADDR_W    (21),
    .FB_BASE   (BASE)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_start(frame_start),
    .line_req   (line_req),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .buf_we     (buf_we),
    .buf_waddr  (buf_waddr),
    .buf_wdata  (buf_wdata),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .line_cnt   (line_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder and write monitor act just after the rising edge, so acks are
  // seen by the DUT on the following edge and tests at negedge see settled counts.
  always @(posedge clk) begin
    #1;
    if (wb_cyc_o && wb_stb_o) begin
      if (wcnt > 0 && wb_adr_o !== held_adr) adr_changes++;
      held_adr = wb_adr_o;
      if (wcnt == wait_n) begin
        wb_ack_i = 1'b1;
        wb_dat_i = {11'h0, wb_adr_o};
        rd_adr.push_back(wb_adr_o);
        ack_cnt++;
        wcnt = 0;
      end else begin
        wb_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      wb_ack_i = 1'b0;
      wcnt = 0;
    end
    if (buf_we) begin
      wr_addr.push_back(buf_waddr);
      wr_data.push_back(buf_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic clear_log();
    rd_adr.delete();
    wr_addr.delete();
    wr_data.delete();
    ack_cnt  = 0;
    done_cnt = 0;
    adr_changes = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    frame_start = 1'b0;
    line_req = 1'b0;
    wait_n = 0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  task automatic pulse_req();
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin bad++; $display("FAIL reset_wb: got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
    total++; if (wb_adr_o !== BASE) begin bad++; $display("FAIL reset_adr: got %0h want %0h", wb_adr_o, BASE); end
    total++; if ({buf_we, buf_waddr, buf_wdata} !== 42'h0) begin bad++; $display("FAIL reset_buf: we=%b addr=%0h data=%0h want 0", buf_we, buf_waddr, buf_wdata); end
    total++; if ({busy, done, overrun, line_cnt} !== 12'h0) begin bad++; $display("FAIL reset_status: busy=%b done=%b ovr=%b cnt=%0d want 0", busy, done, overrun, line_cnt); end
  endtask

  task automatic test_single_line();
    int k;
    do_reset();
    pulse_frame();
    pulse_req();
    total++; if ({wb_cyc_o, wb_stb_o, busy} !== 3'b111) begin bad++; $display("FAIL single_start: cyc/stb/busy=%b want 111", {wb_cyc_o, wb_stb_o, busy}); end
    k = 1;
    while (done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    total++; if (k !== 8) begin bad++; $display("FAIL single_latency: done at cycle %0d want 8", k); end
    total++; if (buf_we !== 1'b1) begin bad++; $display("FAIL single_done_we: buf_we=%b want 1", buf_we); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall: busy=%b want 0", busy); end
    repeat (2) @(negedge clk);
    total++; if (wr_addr.size() !== 4 || done_cnt !== 1) begin bad++; $display("FAIL single_counts: writes=%0d done=%0d want 4/1", wr_addr.size(), done_cnt); end
    for (int i = 0; i < LW; i++) begin
      total++;
      if (i >= wr_addr.size() || i >= rd_adr.size() || wr_addr[i] !== 9'(i) ||
          wr_data[i] !== 32'h100 + i || rd_adr[i] !== BASE + 21'(i)) begin
        bad++;
        $display("FAIL single_word%0d: waddr=%0h data=%0h rd=%0h want %0h/%0h/%0h",
                 i, wr_addr[i], wr_data[i], rd_adr[i], i, 32'h100 + i, BASE + 21'(i));
      end
    end
    total++; if (line_cnt !== 9'd1) begin bad++; $display("FAIL single_line_cnt: got %0d want 1", line_cnt); end
  endtask

  task automatic test_advance_wrap();
    logic [20:0] exp_base[4];
    logic [8:0]  exp_cnt[4];
    int c;
    exp_base = '{21'h100, 21'h104, 21'h108, 21'h100};
    exp_cnt  = '{9'd1, 9'd2, 9'd0, 9'd1};
    do_reset();
    for (int l = 0; l < 4; l++) begin
      clear_log();
      pulse_req();
      wait_idle(c);
      total++;
      if (c >= 500 || rd_adr.size() == 0 || rd_adr[0] !== exp_base[l] || line_cnt !== exp_cnt[l]) begin
        bad++;
        $display("FAIL advance_line%0d: base=%0h cnt=%0d to=%0d want %0h/%0d", l, rd_adr[0], line_cnt, c, exp_base[l], exp_cnt[l]);
      end
    end
  endtask

  task automatic test_wait_states();
    int k;
    do_reset();
    wait_n = 3;
    pulse_req();
    k = 1;
    while (done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    total++; if (k !== 20) begin bad++; $display("FAIL wait_latency: done at cycle %0d want 20", k); end
    repeat (3) @(negedge clk);
    total++; if (adr_changes !== 0) begin bad++; $display("FAIL wait_adr_stable: changes=%0d want 0", adr_changes); end
    total++; if (wr_data.size() !== 4) begin bad++; $display("FAIL wait_writes: got %0d want 4", wr_data.size()); end
    for (int i = 0; i < LW; i++) begin
      total++;
      if (i >= wr_data.size() || wr_data[i] !== 32'h100 + i || wr_addr[i] !== 9'(i)) begin
        bad++;
        $display("FAIL wait_word%0d: addr=%0h data=%0h want %0h/%0h", i, wr_addr[i], wr_data[i], i, 32'h100 + i);
      end
    end
    wait_n = 0;
  endtask

  task automatic test_overrun_pending();
    int c;
    do_reset();
    pulse_req();
    wait_idle(c);
    clear_log();
    pulse_req();
    repeat (2) @(negedge clk);
    line_req = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    frame_start = 1'b0;
    total++; if (overrun !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL ovr_flag: overrun=%b busy=%b want 1/1", overrun, busy); end
    wait_idle(c);
    total++; if (c >= 500) begin bad++; $display("FAIL ovr_timeout: cycles=%0d want <500", c); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || wr_data.size() !== 4 || done_cnt !== 1) begin bad++; $display("FAIL ovr_complete: busy=%b writes=%0d done=%0d want 0/4/1", busy, wr_data.size(), done_cnt); end
    total++; if (rd_adr.size() == 0 || rd_adr[0] !== 21'h104) begin bad++; $display("FAIL ovr_inflight_base: got %0h want 104", rd_adr[0]); end
    total++; if (line_cnt !== 9'd0) begin bad++; $display("FAIL ovr_reload_cnt: got %0d want 0", line_cnt); end
    clear_log();
    pulse_req();
    wait_idle(c);
    total++; if (rd_adr.size() == 0 || rd_adr[0] !== BASE) begin bad++; $display("FAIL ovr_next_base: got %0h want %0h", rd_adr[0], BASE); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_midfetch();
    int k;
    int nw;
    do_reset();
    pulse_req();
    k = 0;
    while (ack_cnt < 2 && k < 100) begin @(negedge clk); k++; end
    total++; if (ack_cnt !== 2) begin bad++; $display("FAIL rst_mid_acks: got %0d want 2", ack_cnt); end
    @(negedge clk);
    total++; if (buf_we !== 1'b1) begin bad++; $display("FAIL rst_mid_gap_we: got %b want 1", buf_we); end
    resetn = 1'b0;
    @(negedge clk);
    total++; if ({wb_cyc_o, wb_stb_o, buf_we} !== 3'b000) begin bad++; $display("FAIL rst_mid_drop: cyc/stb/we=%b want 000", {wb_cyc_o, wb_stb_o, buf_we}); end
    nw = wr_data.size();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (wr_data.size() !== nw || nw !== 2) begin bad++; $display("FAIL rst_mid_no_we: writes=%0d at reset %0d want 2", wr_data.size(), nw); end
    total++; if (line_cnt !== 9'd0 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_state: cnt=%0d busy=%b want 0/0", line_cnt, busy); end
  endtask

  task automatic test_double_buf();
    int c;
    do_reset();
    pulse_frame();
    pulse_req();
    wait_idle(c);
    pulse_req();
    wait_idle(c);
    pulse_frame();
    pulse_req();
    wait_idle(c);
    repeat (2) @(negedge clk);
    total++; if (wr_addr.size() !== 12) begin bad++; $display("FAIL dbuf_writes: got %0d want 12", wr_addr.size()); end
    total++; if (wr_addr[0] !== 9'h000 || wr_addr[3] !== 9'h003) begin bad++; $display("FAIL dbuf_line0: %0h..%0h want 0..3", wr_addr[0], wr_addr[3]); end
    total++; if (wr_addr[4] !== {DBUF, 8'h00} || wr_addr[7] !== {DBUF, 8'h03}) begin bad++; $display("FAIL dbuf_line1: %0h..%0h want %0h..%0h", wr_addr[4], wr_addr[7], {DBUF, 8'h00}, {DBUF, 8'h03}); end
    total++; if (wr_addr[8] !== 9'h000) begin bad++; $display("FAIL dbuf_frame_clear: got %0h want 0", wr_addr[8]); end
  endtask

  initial begin
    resetn = 1'b0;
    frame_start = 1'b0;
    line_req = 1'b0;
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    test_reset();
    test_single_line();
    test_advance_wrap();
    test_wait_states();
    test_overrun_pending();
    test_reset_midfetch();
    test_double_buf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_line_fetch.md
# fb_line_fetch

Wishbone read initiator that streams one LCD scan line of packed RGB565 pixels from SDRAM into the on-chip line buffer on request. It sits between the `sdram_wb` responder and the framebuffer line buffer, replacing CPU copies with hardware fetches. It is triggered from the LCD timing domain's newline/newframe events after they have been synchronised into `clk`. It tracks the current line address itself: it reloads at frame start and advances by one line per fetch.

## Interface

Parameters:
- `LINE_WORDS`, 240, 32-bit words per line (two pixels per word, 480 px).
- `LINES`, 272, lines per frame; line address wraps after this count.
- `FB_BASE`, 21'h0, Wishbone word address of line 0.
- `ADDR_W`, 21, Wishbone word-address width.

Ports:
- `clk`  in  1  — single clock; all logic is synchronous to it.
- `resetn`  in  1  — synchronous, active-low reset.
- `frame_start`  in  1  — single-cycle pulse; reload line address to `FB_BASE`.
- `line_req`  in  1  — single-cycle pulse; fetch the current line.
- `wb_cyc_o`  out  1  — Wishbone cycle.
- `wb_stb_o`  out  1  — Wishbone strobe.
- `wb_we_o`  out  1  — constant 0 (read only).
- `wb_adr_o`  out  ADDR_W  — word address.
- `wb_dat_i`  in  32  — read data.
- `wb_ack_i`  in  1  — acknowledge.
- `buf_we`  out  1  — line-buffer write enable.
- `buf_waddr`  out  9  — line-buffer word address; bit 8 is the bank.
- `buf_wdata`  out  32  — line-buffer write data.
- `busy`  out  1  — fetch in progress.
- `done`  out  1  — single-cycle pulse when a line completes.
- `overrun`  out  1  — sticky; a `line_req` arrived while busy. Cleared only by reset.
- `line_cnt`  out  9  — index of the next line to fetch.

## Operation

- FSM states:
  - IDLE: no transfer.
  - REQ: cyc=stb=1, address stable, waiting for ack.
  - GAP: cyc=stb=0 for exactly one cycle between words, because `sdram_wb` is single-shot per strobe.
- IDLE to REQ:
  - Taken on `line_req`.
  - Word index is cleared to 0.
  - `wb_adr_o` = `line_base`.
- REQ to GAP:
  - Taken on `wb_ack_i`.
  - `wb_dat_i` is captured into `buf_wdata`.
  - `buf_waddr[7:0]` is set to the word index, and `buf_we` is asserted in the next cycle.
- GAP to REQ: the word index and address increment.
- GAP to IDLE:
  - Taken if the word just acked was index `LINE_WORDS-1`.
  - `done` is pulsed.
  - `line_base` += `LINE_WORDS`, and `line_cnt` += 1.
  - If the new `line_cnt` == `LINES`, both wrap: `line_cnt` = 0 and `line_base` = `FB_BASE`.
- Address arithmetic is modulo 2^ADDR_W and uses no multiplier.
- `frame_start` while in IDLE: `line_cnt` = 0 and `line_base` = `FB_BASE` in the next cycle.
  - If it coincides with `line_req`, the reload takes priority and the fetch reads line 0.
- `frame_start` while busy: a pending flag is set, and the reload is applied on the return to IDLE, after the line's normal advance.
- `line_req` while busy: ignored and `overrun` is set. The in-flight line always completes; there is no mid-line abort.
- `wb_ack_i` outside REQ is ignored.
- Reset values:
  - FSM in IDLE.
  - All outputs 0, except `wb_adr_o` = `FB_BASE`.
  - `line_cnt` = 0, and the pending flag is cleared.
- Reset asserted mid-fetch: cyc/stb drop in the next cycle, and no further `buf_we` is issued.

## Timing

- `line_req` at cycle t: `busy` and cyc/stb are high from t+1.
- Ack at cycle a:
  - `buf_we` is high at a+1, with stb low (GAP).
  - The next word's stb rises at a+2.
- Minimum 2 cycles per word; with a zero-wait responder a line takes 2·`LINE_WORDS` cycles.
- `done` and the last `buf_we` occur in the same cycle. `busy` falls in the cycle after that.
- Outputs `wb_*`, `buf_*`, `done` and `busy` are all registered.

## Configuration

- `FB_LINE_FETCH_DOUBLE_BUF_EN` defined:
  - `buf_waddr[8]` is a bank bit that toggles at each `done`, so the display reads one bank while the other fills.
  - The bank resets to 0 and is forced to 0 on `frame_start`, applied with the line-address reload.
- Macro not defined: `buf_waddr[8]` is constant 0 (single bank).

## Structure

- Package `fb_pkg` holds:
  - the FSM state enum (IDLE/REQ/GAP);
  - `LCD_H_PIX`=480, `LCD_V_LINES`=272 and `FB_LINE_WORDS`=240;
  - the line-buffer address width (9).
- No sub-module is needed; the address/counter logic and the FSM fit in one module.

## Test plan

All scenarios use `LINE_WORDS`=4, `LINES`=3, `FB_BASE`=0x100, and a zero-wait responder that returns data = address unless a scenario says otherwise.

- Single line:
  - Stimulus: `frame_start`, then `line_req`.
  - Required response: addresses 0x100–0x103 are read; `buf_waddr` 0–3 with data 0x100–0x103; `done` pulses once; total 8 cycles from cyc rise to `done`.
- Line advance and wrap:
  - Stimulus: four `line_req` with no `frame_start`.
  - Required response: base addresses 0x100, 0x104, 0x108, then 0x100; `line_cnt` reads 1, 2, 0, 1.
- Wait states:
  - Stimulus: responder delays each ack by 3 cycles.
  - Required response: stb is held with a stable address until ack; the same data is written; no extra `buf_we`.
- Overrun and pending reload:
  - Stimulus: `line_req` and `frame_start` both pulsed mid-line.
  - Required response: `overrun`=1 stays set; the line completes; the next `line_req` reads from 0x100.
- Reset mid-fetch:
  - Stimulus: `resetn`=0 after the 2nd ack.
  - Required response: cyc/stb = 0 next cycle; no further `buf_we`; `line_cnt`=0.
- Double buffer (macro defined):
  - Stimulus: two consecutive lines.
  - Required response: `buf_waddr[8]` = 0 for line 0 and 1 for line 1.
